// File: rtl/seq_sub32.sv
// Multi-cycle subtractor: computes minuend - subtrahend - bin one lookahead slice per clock,
// LSB slice first, with the borrow carried between cycles in a register.
module seq_sub32 #(
    parameter int WIDTH   = 32,
    parameter int SLICE_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);
    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   nb_q, nb_d;
    logic               borrow_q, borrow_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;
    logic               out_valid_q, out_valid_d;

    int                 base;
    logic [SLICE_W-1:0] a_s, b_s, g_s, p_s, sum_s;
    logic [SLICE_W:0]   carry;
    logic               pp;

    // Slice adder: A_k + ~B_k + ~borrow, every carry expanded as a flat generate/propagate term.
    always_comb begin
        base     = int'(cnt_q) * SLICE_W;
        a_s      = a_q[base +: SLICE_W];
        b_s      = nb_q[base +: SLICE_W];
        g_s      = a_s & b_s;
        p_s      = a_s ^ b_s;
        carry    = '0;
        carry[0] = ~borrow_q;
        pp       = 1'b0;
        for (int i = 0; i < SLICE_W; i++) begin
            carry[i+1] = g_s[i];
            pp         = p_s[i];
            for (int j = i - 1; j >= 0; j--) begin
                carry[i+1] = carry[i+1] | (pp & g_s[j]);
                pp         = pp & p_s[j];
            end
            carry[i+1] = carry[i+1] | (pp & ~borrow_q);
        end
        sum_s = p_s ^ carry[SLICE_W-1:0];
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        nb_d        = nb_q;
        borrow_d    = borrow_q;
        cnt_d       = cnt_q;
        diff_d      = diff_q;
        bout_d      = bout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = minuend;
                    nb_d     = ~subtrahend;
                    borrow_d = bin;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                diff_d[base +: SLICE_W] = sum_s;
                borrow_d = ~carry[SLICE_W];
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(NSLICE - 1)) begin
                    bout_d      = ~carry[SLICE_W];
                    ovf_d       = (a_q[WIDTH-1] ^ ~nb_q[WIDTH-1]) & (a_q[WIDTH-1] ^ diff_d[WIDTH-1]);
                    zero_d      = (diff_d == '0);
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            nb_q        <= '0;
            borrow_q    <= 1'b0;
            cnt_q       <= '0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            nb_q        <= nb_d;
            borrow_q    <= borrow_d;
            cnt_q       <= cnt_d;
            diff_q      <= diff_d;
            bout_q      <= bout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_seq_sub32.sv
// Self-checking bench for seq_sub32: directed vector table, backpressure and reset
// sequences, then randomized operations against an arithmetic reference model.
module tb_seq_sub32;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] minuend;
    logic [31:0] subtrahend;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;

    int compared   = 0;
    int mismatched = 0;

    seq_sub32 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .minuend    (minuend),
        .subtrahend (subtrahend),
        .bin        (bin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
        .bout       (bout),
        .ovf        (ovf),
        .zero       (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bi;
        logic [31:0] d;
        logic        bo;
        logic        ov;
        logic        z;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference: plain wide unsigned / signed arithmetic.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic bi,
                         output logic [31:0] d, output logic bo, output logic ov, output logic z);
        longint ua, ub, r, sr;
        ua = longint'(a);
        ub = longint'(b);
        r  = ua - ub - longint'(bi);
        d  = r[31:0];
        bo = (ua < ub + longint'(bi));
        sr = longint'($signed(a)) - longint'($signed(b)) - longint'(bi);
        ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        z  = (d == 32'd0);
    endtask

    // Called #1 after a rising edge. Returns results sampled when out_valid is seen.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic bi,
                         output logic [31:0] d, output logic bo, output logic ov,
                         output logic z, output int lat);
        int w;
        minuend    = a;
        subtrahend = b;
        bin        = bi;
        in_valid   = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        @(posedge clk); #1;
        in_valid   = 1'b0;
        minuend    = $urandom;
        subtrahend = $urandom;
        bin        = 1'($urandom_range(1));
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        d  = diff;
        bo = bout;
        ov = ovf;
        z  = zero;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [31:0] a, input logic [31:0] b,
                                input logic bi, input int idle_cycles);
        logic [31:0] d, ed;
        logic bo, ov, z, ebo, eov, ez;
        int lat;
        model(a, b, bi, ed, ebo, eov, ez);
        do_op(a, b, bi, d, bo, ov, z, lat);
        chk({tag, " latency"}, 64'(lat), 64'd4);
        chk({tag, " diff"}, 64'(d), 64'(ed));
        chk({tag, " bout"}, 64'(bo), 64'(ebo));
        chk({tag, " ovf"}, 64'(ov), 64'(eov));
        chk({tag, " zero"}, 64'(z), 64'(ez));
        for (int i = 0; i < idle_cycles; i++) begin
            @(posedge clk); #1;
        end
        release_out();
    endtask

    initial begin
        logic [31:0] d, held;
        logic bo, ov, z;
        int lat;

        vecs[0] = '{32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{32'h12345678, 32'h12345677, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{32'h00000000, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{32'h00000100, 32'h00000001, 1'b0, 32'h000000FF, 1'b0, 1'b0, 1'b0};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        minuend    = '0;
        subtrahend = '0;
        bin        = 1'b0;
        #12;
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset diff", 64'(diff), 64'd0);
        chk("reset flags", 64'({bout, ovf, zero}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].bi, d, bo, ov, z, lat);
            chk($sformatf("vec%0d latency", i), 64'(lat), 64'd4);
            chk($sformatf("vec%0d diff", i), 64'(d), 64'(vecs[i].d));
            chk($sformatf("vec%0d bout", i), 64'(bo), 64'(vecs[i].bo));
            chk($sformatf("vec%0d ovf", i), 64'(ov), 64'(vecs[i].ov));
            chk($sformatf("vec%0d zero", i), 64'(z), 64'(vecs[i].z));
            release_out();
            chk($sformatf("vec%0d out_valid drop", i), 64'(out_valid), 64'd0);
            chk($sformatf("vec%0d in_ready back", i), 64'(in_ready), 64'd1);
            chk($sformatf("vec%0d diff retained", i), 64'(diff), 64'(vecs[i].d));
        end

        // Backpressure in DONE with upstream churning.
        do_op(32'h00000005, 32'h00000003, 1'b0, d, bo, ov, z, lat);
        held = d;
        for (int i = 0; i < 3; i++) begin
            in_valid   = 1'b1;
            minuend    = $urandom;
            subtrahend = $urandom;
            bin        = 1'($urandom_range(1));
            @(posedge clk); #1;
            chk($sformatf("bp%0d in_ready", i), 64'(in_ready), 64'd0);
            chk($sformatf("bp%0d out_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("bp%0d diff", i), 64'(diff), 64'(held));
            chk($sformatf("bp%0d flags", i), 64'({bout, ovf, zero}), 64'd0);
        end
        in_valid = 1'b0;
        release_out();
        chk("bp release out_valid", 64'(out_valid), 64'd0);
        chk("bp release in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
        end
        chk("bp no capture", 64'({out_valid, in_ready}), 64'b01);

        // Reset during the second CALC cycle.
        minuend    = 32'hDEADBEEF;
        subtrahend = 32'h00000001;
        bin        = 1'b0;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", 64'(out_valid), 64'd0);
        chk("midrst diff", 64'(diff), 64'd0);
        chk("midrst in_ready", 64'(in_ready), 64'd1);
        chk("midrst flags", 64'({bout, ovf, zero}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post rst idle", 64'({out_valid, in_ready}), 64'b01);
        check_result("post rst", 32'h00000010, 32'h00000001, 1'b0, 0);
        chk("post rst diff value", 64'(diff), 64'h0000000F);

        // Randomized operations, with biased corner operands and random output stalls.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            case ($urandom_range(3))
                0: a = 32'h0;
                1: a = 32'hFFFFFFFF;
                2: a = {1'b1, 31'($urandom)};
                default: a = $urandom;
            endcase
            case ($urandom_range(3))
                0: b = a;
                1: b = 32'hFFFFFFFF;
                2: b = a + 32'd1;
                default: b = $urandom;
            endcase
            check_result($sformatf("rnd%0d", i), a, b, 1'($urandom_range(1)),
                         int'($urandom_range(2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
